// File: rtl/serializer_pkg.sv
// Shared constants and helpers for the parallel-in/serial-out frame serializer.
package serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit-counter width; never below 1 so the counter always exists.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Modulo-WIDTH bit counter tracking the position within the current frame.
module piso_bit_cnt
    import serializer_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          is_last
);

    assign is_last = (cnt == CW'(WIDTH - 1));

    // Clear wins over inc so a reload on the last-bit edge restarts at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= is_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_frame_serializer.sv
// Serializes WIDTH-bit words one bit per enabled clock, driving 0 whenever no frame bit is valid.
module piso_frame_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt_unused;
    logic             is_last;
    logic             shift_en;
    logic             last_bit;
    logic             accept;
    logic             cur_bit;

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .inc     (shift_en),
        .cnt     (bit_cnt_unused),
        .is_last (is_last)
    );

    assign cur_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus handshake/serial outputs; a stalled SHIFT cycle emits nothing.
    always_comb begin
        state_d    = state_q;
        shift_en   = (state_q == ST_SHIFT) && enable;
        last_bit   = shift_en && is_last;
        load_ready = (state_q == ST_IDLE) || last_bit;
        accept     = load_valid && load_ready;
        sout_valid = shift_en;
        sout       = shift_en && cur_bit;

        if (accept) begin
            state_d = ST_SHIFT;
        end else if (last_bit) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= data_in;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_bit;
        end
    end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench: MSB-first and LSB-first serializers driven by shared stimulus.
module tb_piso_frame_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] data_in;
    logic       enable;

    logic m_ready, m_sout, m_valid, m_done;
    logic l_ready, l_sout, l_valid, l_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_frame_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .data_in    (data_in),
        .enable     (enable),
        .sout       (m_sout),
        .sout_valid (m_valid),
        .frame_done (m_done)
    );

    piso_frame_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .data_in    (data_in),
        .enable     (enable),
        .sout       (l_sout),
        .sout_valid (l_valid),
        .frame_done (l_done)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; data_in = 8'h00; enable = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if ({m_sout, m_valid, m_done, m_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_state: got sout/valid/done/ready=%b expected 0001", {m_sout, m_valid, m_done, m_ready});
        end
        reset = 1'b0;
        tick(); #1;
        checks++;
        if ({l_sout, l_valid, l_done, l_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_state_lsb: got %b expected 0001", {l_sout, l_valid, l_done, l_ready});
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp;
        exp = 8'hF0;
        load_valid = 1'b1; data_in = 8'hF0; enable = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #1;
            checks++;
            if (c <= 8) begin
                if (m_sout !== exp[8-c] || m_valid !== 1'b1 || m_done !== 1'b0 || m_ready !== (c == 8)) begin
                    errors++;
                    $display("FAIL basic_c%0d: got sout=%b valid=%b done=%b ready=%b expected sout=%b valid=1 done=0 ready=%b",
                             c, m_sout, m_valid, m_done, m_ready, exp[8-c], (c == 8));
                end
            end else if (m_done !== 1'b1 || m_valid !== 1'b0 || m_sout !== 1'b0 || m_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_done: got done=%b valid=%b sout=%b ready=%b expected 1 0 0 1", m_done, m_valid, m_sout, m_ready);
            end
            tick();
        end
        #1;
        checks++;
        if (m_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got done=%b expected 0", m_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        exp = 16'hFF0F;
        load_valid = 1'b1; data_in = 8'hFF; enable = 1'b1;
        tick();
        data_in = 8'h0F;
        for (int c = 1; c <= 17; c++) begin
            #1;
            checks++;
            if (c <= 16) begin
                if (m_sout !== exp[16-c] || m_valid !== 1'b1 || m_done !== (c == 9)) begin
                    errors++;
                    $display("FAIL b2b_c%0d: got sout=%b valid=%b done=%b expected sout=%b valid=1 done=%b",
                             c, m_sout, m_valid, m_done, exp[16-c], (c == 9));
                end
            end else if (m_done !== 1'b1 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_done2: got done=%b valid=%b expected 1 0", m_done, m_valid);
            end
            tick();
            if (c == 8) load_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        logic en_c;
        load_valid = 1'b1; data_in = 8'hFF; enable = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            en_c = !(c == 4 || c == 5);
            enable = en_c;
            #1;
            checks++;
            if (c <= 10) begin
                if (m_sout !== en_c || m_valid !== en_c || m_done !== 1'b0 || m_ready !== (c == 10)) begin
                    errors++;
                    $display("FAIL stall_c%0d: got sout=%b valid=%b done=%b ready=%b expected sout=%b valid=%b done=0 ready=%b",
                             c, m_sout, m_valid, m_done, m_ready, en_c, en_c, (c == 10));
                end
            end else if (m_done !== 1'b1 || m_valid !== 1'b0 || m_sout !== 1'b0) begin
                errors++;
                $display("FAIL stall_done: got done=%b valid=%b sout=%b expected 1 0 0", m_done, m_valid, m_sout);
            end
            tick();
        end
        enable = 1'b1;
    endtask

    task automatic test_bit_order();
        load_valid = 1'b1; data_in = 8'h01; enable = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            checks++;
            if (l_sout !== (c == 1) || m_sout !== (c == 8) || l_valid !== 1'b1) begin
                errors++;
                $display("FAIL order_c%0d: got lsb_sout=%b msb_sout=%b lsb_valid=%b expected %b %b 1",
                         c, l_sout, m_sout, l_valid, (c == 1), (c == 8));
            end
            tick();
        end
        #1;
        checks++;
        if (l_done !== 1'b1 || m_done !== 1'b1) begin
            errors++;
            $display("FAIL order_done: got lsb_done=%b msb_done=%b expected 1 1", l_done, m_done);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp;
        exp = 8'hAA;
        load_valid = 1'b1; data_in = 8'hFF; enable = 1'b1;
        tick();
        load_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (m_sout !== 1'b0 || m_valid !== 1'b0 || m_ready !== 1'b1 || m_done !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle_%0d: got sout=%b valid=%b ready=%b done=%b expected 0 0 1 0",
                         c, m_sout, m_valid, m_ready, m_done);
            end
            tick();
        end
        load_valid = 1'b1; data_in = 8'hAA;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            #1;
            checks++;
            if (c <= 8) begin
                if (m_sout !== exp[8-c] || m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_aa_c%0d: got sout=%b valid=%b expected %b 1", c, m_sout, m_valid, exp[8-c]);
                end
            end else if (m_done !== 1'b1) begin
                errors++;
                $display("FAIL midreset_done: got done=%b expected 1", m_done);
            end
            tick();
        end
    endtask

    task automatic test_busy_load();
        logic [15:0] exp;
        exp = 16'hA555;
        load_valid = 1'b1; data_in = 8'hA5; enable = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c >= 2 && c <= 8) begin
                load_valid = 1'b1; data_in = 8'h55;
            end else begin
                load_valid = 1'b0;
            end
            #1;
            checks++;
            if (c <= 16) begin
                if (m_sout !== exp[16-c] || m_valid !== 1'b1 || m_ready !== (c == 8 || c == 16)) begin
                    errors++;
                    $display("FAIL busy_c%0d: got sout=%b valid=%b ready=%b expected sout=%b valid=1 ready=%b",
                             c, m_sout, m_valid, m_ready, exp[16-c], (c == 8 || c == 16));
                end
            end else if (m_done !== 1'b1 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL busy_done: got done=%b valid=%b expected 1 0", m_done, m_valid);
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_stall();
        test_bit_order();
        test_mid_reset();
        test_busy_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
